// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - micro-op types, opcode/ALU encodings and issue entry for issue_queue
package issue_queue_pkg;

  localparam int UOP_XLEN = 32;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;
  // Branch conditions reuse the alu_op field of BRANCH micro-ops
  localparam logic [3:0] ALU_BEQ  = 4'ha;
  localparam logic [3:0] ALU_BNE  = 4'hb;
  localparam logic [3:0] ALU_BLT  = 4'hc;
  localparam logic [3:0] ALU_BGE  = 4'hd;
  localparam logic [3:0] ALU_BLTU = 4'he;
  localparam logic [3:0] ALU_BGEU = 4'hf;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        is_immediate;
  } uop_t;

  // pc is sized for the RV32 micro-op; the queue is instantiated with XLEN = UOP_XLEN
  typedef struct packed {
    uop_t                uop;
    logic [UOP_XLEN-1:0] pc;
  } issue_entry_t;

  function automatic logic branch_cond(input logic [3:0] alu_op, input logic eq,
                                       input logic lt_s, input logic lt_u);
    case (alu_op)
      ALU_BEQ:  return eq;
      ALU_BNE:  return !eq;
      ALU_BLT:  return lt_s;
      ALU_BGE:  return !lt_s;
      ALU_BLTU: return lt_u;
      ALU_BGEU: return !lt_u;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - decode and issue handshake bundle for issue_queue
interface issue_queue_if #(parameter int XLEN = issue_queue_pkg::UOP_XLEN) ();
  import issue_queue_pkg::*;

  logic            i_dec_valid;
  logic            o_dec_ready;
  uop_t            i_uop;
  logic [XLEN-1:0] i_dec_pc;
  logic            o_alu_valid;
  logic            i_alu_ready;
  logic            o_lsu_valid;
  logic            i_lsu_ready;
  uop_t            o_uop;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_op1;
  logic [XLEN-1:0] o_op2;

  modport slave (
    input  i_dec_valid, i_uop, i_dec_pc, i_alu_ready, i_lsu_ready,
    output o_dec_ready, o_alu_valid, o_lsu_valid, o_uop, o_pc, o_op1, o_op2
  );

  modport master (
    output i_dec_valid, i_uop, i_dec_pc, i_alu_ready, i_lsu_ready,
    input  o_dec_ready, o_alu_valid, o_lsu_valid, o_uop, o_pc, o_op1, o_op2
  );

endinterface

// File: rtl/issue_queue_arf.sv
// rtl/issue_queue_arf.sv - 2-read 1-write architectural register file, x0 hard-wired to zero
module issue_queue_arf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [32];

  // Register write; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - DEPTH-entry in-order issue buffer; ISSUE_SCOREBOARD_EN adds the load-use scoreboard
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 2,
  parameter int XLEN    = UOP_XLEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  issue_queue_if.slave                  bus,
  input  logic                          i_flush,
  input  logic                          i_wb_en,
  input  logic [4:0]                    i_wb_rd,
  input  logic [XLEN-1:0]               i_wb_data,
  input  logic [NUM_FWD-1:0]            i_fwd_valid,
  input  logic [NUM_FWD-1:0][4:0]       i_fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]  i_fwd_data,
  output logic                          o_branch_taken,
  output logic [XLEN-1:0]               o_branch_target,
  output logic [$clog2(DEPTH):0]        o_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  issue_entry_t     mem_q [DEPTH];
  issue_entry_t     head;

  logic            head_valid, full, push, pop, hazard, issue_fire;
  logic            is_alu, is_lsu, unit_ready, cond, taken;
  logic [4:0]      src_rs  [2];
  logic [XLEN-1:0] src_arf [2];
  logic [XLEN-1:0] src_val [2];
  logic [XLEN-1:0] imm_x, target;

  assign head        = mem_q[head_q];
  assign head_valid  = (count_q != '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign src_rs[0]   = head.uop.rs1;
  assign src_rs[1]   = head.uop.rs2;
  assign imm_x       = XLEN'($signed(head.uop.imm));
  assign o_occupancy = count_q;
  assign bus.o_dec_ready = !full;

  issue_queue_arf #(.XLEN(XLEN)) u_arf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (i_wb_en),
    .waddr_i  (i_wb_rd),
    .wdata_i  (i_wb_data),
    .raddr1_i (src_rs[0]),
    .raddr2_i (src_rs[1]),
    .rdata1_o (src_arf[0]),
    .rdata2_o (src_arf[1])
  );

  // Head operands: ARF, overridden by same-cycle write-back, then by forward ports (port 0 applied last so it wins)
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_val[s] = src_arf[s];
      if (i_wb_en && i_wb_rd == src_rs[s]) src_val[s] = i_wb_data;
      for (int p = NUM_FWD - 1; p >= 0; p--) begin
        if (i_fwd_valid[p] && i_fwd_rd[p] == src_rs[s]) src_val[s] = i_fwd_data[p];
      end
      if (src_rs[s] == 5'd0) src_val[s] = '0;
    end
  end

  // Route the head, decide issue, resolve branches and drive the shared payload
  always_comb begin
    is_alu = 1'b0;
    is_lsu = 1'b0;
    case (head.uop.opcode)
      OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC,
      OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR: is_alu = 1'b1;
      OPCODE_LOAD, OPCODE_STORE:              is_lsu = 1'b1;
      default: ;
    endcase
    // Unrouted opcodes need no unit, so they drain without raising a valid
    unit_ready = is_alu ? bus.i_alu_ready : (is_lsu ? bus.i_lsu_ready : 1'b1);
    issue_fire = head_valid && unit_ready && !hazard && !i_flush;
    bus.o_alu_valid = head_valid && is_alu && !hazard && !i_flush;
    bus.o_lsu_valid = head_valid && is_lsu && !hazard && !i_flush;

    cond  = branch_cond(head.uop.alu_op, src_val[0] == src_val[1],
                        $signed(src_val[0]) < $signed(src_val[1]), src_val[0] < src_val[1]);
    taken = issue_fire && ((head.uop.opcode == OPCODE_BRANCH && cond) ||
                           head.uop.opcode == OPCODE_JAL || head.uop.opcode == OPCODE_JALR);
    target = (head.uop.opcode == OPCODE_JALR) ? ((src_val[0] + imm_x) & ~XLEN'(1))
                                              : (head.pc + imm_x);
    o_branch_taken  = taken;
    o_branch_target = taken ? target : '0;

    bus.o_uop = head_valid ? head.uop : '0;
    bus.o_pc  = head_valid ? head.pc  : '0;
    bus.o_op1 = '0;
    if (head_valid) begin
      if (head.uop.uses_rs1)                   bus.o_op1 = src_val[0];
      else if (head.uop.opcode == OPCODE_AUIPC) bus.o_op1 = head.pc;
    end
    bus.o_op2 = '0;
    if (head_valid) begin
      if (head.uop.opcode == OPCODE_JAL || head.uop.opcode == OPCODE_JALR) bus.o_op2 = XLEN'(4);
      else if (head.uop.is_immediate) bus.o_op2 = imm_x;
      else if (head.uop.uses_rs2)     bus.o_op2 = src_val[1];
    end
  end

  // Pointer/count next state; flush and taken redirects empty the buffer and drop the push
  always_comb begin
    push    = bus.i_dec_valid && !full && !i_flush && !taken;
    pop     = issue_fire;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush || taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observed through count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{uop: bus.i_uop, pc: bus.i_dec_pc};
  end

`ifdef ISSUE_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;
  logic [1:0]  src_hit;

  // A pending source is cleared for issue when any valid forward port carries it
  always_comb begin
    src_hit = '0;
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < NUM_FWD; p++) begin
        if (i_fwd_valid[p] && i_fwd_rd[p] == src_rs[s]) src_hit[s] = 1'b1;
      end
    end
  end

  assign hazard = head_valid &&
                  ((head.uop.uses_rs1 && pend_q[src_rs[0]] && !src_hit[0]) ||
                   (head.uop.uses_rs2 && pend_q[src_rs[1]] && !src_hit[1]));

  // Pending mask: write-back clears, load issue sets, set wins on a collision
  always_comb begin
    pend_d = pend_q;
    if (i_wb_en) pend_d[i_wb_rd] = 1'b0;
    if (issue_fire && head.uop.opcode == OPCODE_LOAD && head.uop.rd != 5'd0)
      pend_d[head.uop.rd] = 1'b1;
  end

  // Pending mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end
`else
  assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_flush;
  logic              i_wb_en;
  logic [4:0]        i_wb_rd;
  logic [31:0]       i_wb_data;
  logic [1:0]        i_fwd_valid;
  logic [1:0][4:0]   i_fwd_rd;
  logic [1:0][31:0]  i_fwd_data;
  logic              o_branch_taken;
  logic [31:0]       o_branch_target;
  logic [2:0]        o_occupancy;
  int                n_assert = 0;
  int                n_fail = 0;

  issue_queue_if #(.XLEN(32)) bus ();

  issue_queue #(.DEPTH(4), .NUM_FWD(2), .XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .i_flush         (i_flush),
    .i_wb_en         (i_wb_en),
    .i_wb_rd         (i_wb_rd),
    .i_wb_data       (i_wb_data),
    .i_fwd_valid     (i_fwd_valid),
    .i_fwd_rd        (i_fwd_rd),
    .i_fwd_data      (i_fwd_data),
    .o_branch_taken  (o_branch_taken),
    .o_branch_target (o_branch_target),
    .o_occupancy     (o_occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic uop_t mk(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [3:0] aop, input logic [31:0] imm,
                              input logic u1, input logic u2, input logic im);
    uop_t u;
    u.opcode = opc; u.rd = rd; u.rs1 = rs1; u.rs2 = rs2; u.alu_op = aop; u.imm = imm;
    u.uses_rs1 = u1; u.uses_rs2 = u2; u.is_immediate = im;
    return u;
  endfunction

  function automatic uop_t addi(input logic [4:0] rd, input logic [31:0] imm);
    return mk(OPCODE_OP_IMM, rd, 5'd0, 5'd0, ALU_ADD, imm, 1'b1, 1'b0, 1'b1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input uop_t u, input logic [31:0] pc);
    bus.i_dec_valid = 1'b1;
    bus.i_uop       = u;
    bus.i_dec_pc    = pc;
    tick();
    bus.i_dec_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    i_wb_en = 1'b1; i_wb_rd = rd; i_wb_data = data;
    tick();
    i_wb_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_wb_en = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    i_fwd_valid = '0; i_fwd_rd = '0; i_fwd_data = '0;
    bus.i_dec_valid = 1'b0; bus.i_uop = '0; bus.i_dec_pc = '0;
    bus.i_alu_ready = 1'b0; bus.i_lsu_ready = 1'b0;
    #1;
    chk("rst_dec_ready", bus.o_dec_ready, 1);
    chk("rst_occ", o_occupancy, 0);
    chk("rst_alu_valid", bus.o_alu_valid, 0);
    chk("rst_lsu_valid", bus.o_lsu_valid, 0);
    chk("rst_taken", o_branch_taken, 0);
    chk("rst_target", o_branch_target, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd5);

    // fill to DEPTH with the ALU stalled, then drain one per cycle
    for (int k = 1; k <= 4; k++) push(addi(5'(10 + k), 32'(k)), 32'(k * 4));
    chk("fill_occ", o_occupancy, 4);
    chk("fill_dec_ready", bus.o_dec_ready, 0);
    chk("fill_alu_valid", bus.o_alu_valid, 1);
    chk("fill_op1", bus.o_op1, 0);
    bus.i_alu_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", bus.o_alu_valid, 1);
      chk("drain_op2", bus.o_op2, k);
      chk("drain_pc", bus.o_pc, k * 4);
      chk("drain_occ", o_occupancy, 5 - k);
      tick();
    end
    chk("drain_empty_occ", o_occupancy, 0);
    chk("drain_empty_valid", bus.o_alu_valid, 0);

    // taken BEQ with 3 younger entries behind it
    bus.i_alu_ready = 1'b0;
    push(mk(OPCODE_BRANCH, 5'd0, 5'd1, 5'd2, ALU_BEQ, 32'd16, 1'b1, 1'b1, 1'b0), 32'h100);
    for (int k = 0; k < 3; k++) push(addi(5'd20, 32'd7), 32'h104 + 32'(k * 4));
    chk("beq_occ", o_occupancy, 4);
    bus.i_alu_ready = 1'b1;
    #1;
    chk("beq_taken", o_branch_taken, 1);
    chk("beq_target", o_branch_target, 32'h110);
    tick();
    chk("beq_occ_after", o_occupancy, 0);
    chk("beq_taken_after", o_branch_taken, 0);
    chk("beq_target_after", o_branch_target, 0);

    // not-taken BNE on equal operands still issues
    push(mk(OPCODE_BRANCH, 5'd0, 5'd1, 5'd2, ALU_BNE, 32'd16, 1'b1, 1'b1, 1'b0), 32'h200);
    chk("bne_valid", bus.o_alu_valid, 1);
    chk("bne_taken", o_branch_taken, 0);
    tick();
    chk("bne_occ", o_occupancy, 0);

    // JALR x9, 0x21(x1): target (5+0x21)&~1, same-cycle push is dropped
    bus.i_alu_ready = 1'b0;
    push(mk(OPCODE_JALR, 5'd9, 5'd1, 5'd0, ALU_ADD, 32'h21, 1'b1, 1'b0, 1'b1), 32'h300);
    chk("jalr_op1", bus.o_op1, 5);
    chk("jalr_op2", bus.o_op2, 4);
    bus.i_alu_ready = 1'b1;
    bus.i_dec_valid = 1'b1;
    bus.i_uop = addi(5'd21, 32'd1);
    #1;
    chk("jalr_taken", o_branch_taken, 1);
    chk("jalr_target", o_branch_target, 32'h26);
    tick();
    bus.i_dec_valid = 1'b0;
    chk("jalr_occ", o_occupancy, 0);

    // forwarding priority, write-back bypass, x0 never forwarded
    bus.i_alu_ready = 1'b0;
    push(mk(OPCODE_OP, 5'd4, 5'd3, 5'd3, ALU_ADD, 32'd0, 1'b1, 1'b1, 1'b0), 32'h400);
    i_fwd_valid = 2'b11; i_fwd_rd[0] = 5'd3; i_fwd_rd[1] = 5'd3;
    i_fwd_data[0] = 32'hAA; i_fwd_data[1] = 32'hBB;
    #1;
    chk("fwd_both_op1", bus.o_op1, 32'hAA);
    chk("fwd_both_op2", bus.o_op2, 32'hAA);
    i_fwd_valid = 2'b10;
    #1;
    chk("fwd_port1_op1", bus.o_op1, 32'hBB);
    i_fwd_valid = 2'b00;
    #1;
    chk("fwd_none_op1", bus.o_op1, 0);
    i_wb_en = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'h77;
    #1;
    chk("wb_bypass_op2", bus.o_op2, 32'h77);
    i_wb_en = 1'b0;
    bus.i_alu_ready = 1'b1;
    tick();
    i_fwd_valid = 2'b01; i_fwd_rd[0] = 5'd0; i_fwd_data[0] = 32'hCC;
    push(mk(OPCODE_OP, 5'd7, 5'd0, 5'd0, ALU_ADD, 32'd0, 1'b1, 1'b1, 1'b0), 32'h404);
    chk("x0_op1", bus.o_op1, 0);
    chk("x0_op2", bus.o_op2, 0);
    tick();
    i_fwd_valid = 2'b00;
    chk("x0_occ", o_occupancy, 0);

    // unrouted opcode drains silently
    bus.i_alu_ready = 1'b0;
    push(mk(7'h0f, 5'd0, 5'd0, 5'd0, ALU_ADD, 32'd0, 1'b0, 1'b0, 1'b0), 32'h500);
    chk("misc_alu_valid", bus.o_alu_valid, 0);
    chk("misc_lsu_valid", bus.o_lsu_valid, 0);
    tick();
    chk("misc_occ", o_occupancy, 0);

    // LW x5, 8(x1) goes to the LSU
    push(mk(OPCODE_LOAD, 5'd5, 5'd1, 5'd0, ALU_ADD, 32'd8, 1'b1, 1'b0, 1'b1), 32'h600);
    chk("lw_lsu_valid", bus.o_lsu_valid, 1);
    chk("lw_alu_valid", bus.o_alu_valid, 0);
    chk("lw_op1", bus.o_op1, 5);
    chk("lw_op2", bus.o_op2, 8);
    bus.i_lsu_ready = 1'b1;
    tick();
    bus.i_lsu_ready = 1'b0;
    chk("lw_occ", o_occupancy, 0);
    bus.i_alu_ready = 1'b1;
    push(mk(OPCODE_OP, 5'd6, 5'd5, 5'd0, ALU_ADD, 32'd0, 1'b1, 1'b1, 1'b0), 32'h604);
`ifdef ISSUE_SCOREBOARD_EN
    chk("sb_held_valid", bus.o_alu_valid, 0);
    tick();
    chk("sb_held_occ", o_occupancy, 1);
    i_fwd_valid = 2'b10; i_fwd_rd[1] = 5'd5; i_fwd_data[1] = 32'h66;
    #1;
    chk("sb_fwd_valid", bus.o_alu_valid, 1);
    chk("sb_fwd_op1", bus.o_op1, 32'h66);
    i_fwd_valid = 2'b00;
    #1;
    chk("sb_nofwd_valid", bus.o_alu_valid, 0);
    i_wb_en = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h55;
    tick();
    i_wb_en = 1'b0;
    chk("sb_wb_valid", bus.o_alu_valid, 1);
    chk("sb_wb_op1", bus.o_op1, 32'h55);
    tick();
    chk("sb_occ", o_occupancy, 0);
`else
    chk("nosb_valid", bus.o_alu_valid, 1);
    chk("nosb_op1", bus.o_op1, 0);
    tick();
    chk("nosb_occ", o_occupancy, 0);
`endif

    // flush with 3 entries and a pending push
    bus.i_alu_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(addi(5'd22, 32'd3), 32'h700);
    chk("flush_pre_occ", o_occupancy, 3);
    i_flush = 1'b1;
    bus.i_dec_valid = 1'b1;
    bus.i_uop = addi(5'd23, 32'd9);
    bus.i_alu_ready = 1'b1;
    #1;
    chk("flush_alu_valid", bus.o_alu_valid, 0);
    chk("flush_taken", o_branch_taken, 0);
    tick();
    i_flush = 1'b0;
    bus.i_dec_valid = 1'b0;
    chk("flush_occ", o_occupancy, 0);
    chk("flush_dec_ready", bus.o_dec_ready, 1);

    // asynchronous reset mid-cycle
    bus.i_alu_ready = 1'b0;
    push(addi(5'd24, 32'd1), 32'h800);
    push(addi(5'd25, 32'd2), 32'h804);
    chk("arst_pre_occ", o_occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", o_occupancy, 0);
    chk("arst_alu_valid", bus.o_alu_valid, 0);
    chk("arst_pc", bus.o_pc, 0);
    chk("arst_dec_ready", bus.o_dec_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised successor to the single-slot issue stage: a DEPTH-entry in-order issue buffer between Decode and the ALU/LSU. It uses valid/ready handshakes on both sides instead of stall wires. It reads operands from an internal ARF with an N-port forwarding network, and resolves branches/jumps at issue, squashing younger buffered entries. An optional load scoreboard blocks load-use hazards.

## Interface
- DEPTH, 4, buffer entries; power of two, ≥2
- NUM_FWD, 2, forwarding ports; index 0 highest priority
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_dec_valid / o_dec_ready  in/out  1  decode handshake
- i_uop  in  uop_t  decoded micro-op
- i_dec_pc  in  XLEN  PC of i_uop
- i_flush  in  1  pipeline flush from downstream
- i_wb_en, i_wb_rd, i_wb_data  in  1/5/XLEN  ARF write port
- i_fwd_valid  in  NUM_FWD  forward port carries a result
- i_fwd_rd  in  NUM_FWD×5  forward destination
- i_fwd_data  in  NUM_FWD×XLEN  forward value
- o_branch_taken  out  1  redirect fetch this cycle
- o_branch_target  out  XLEN  redirect PC
- o_alu_valid / i_alu_ready  out/in  1  ALU handshake
- o_lsu_valid / i_lsu_ready  out/in  1  LSU handshake
- o_uop, o_pc, o_op1, o_op2  out  uop_t/XLEN/XLEN/XLEN  shared issue payload: op1/op2 to ALU, addr base/store data to LSU
- o_occupancy  out  $clog2(DEPTH)+1  current entry count

## Operation
- Circular FIFO of {uop, pc}; head/tail pointers $clog2(DEPTH) bits wrap modulo DEPTH; separate count register.
- o_dec_ready = (count != DEPTH). Push on i_dec_valid && o_dec_ready. No same-cycle push/pop bypass at full.
- Head operands: ARF read at head rs1/rs2; forwarding scans ports 0..NUM_FWD-1, first match with i_fwd_valid && rd==rs && rs!=0 wins; rs==0 → 0.
- op1 = fwd rs1 if uses_rs1, else PC for AUIPC, else 0. op2 = 4 for JAL/JALR, else imm if is_immediate, else fwd rs2.
- Routing: OP, OP_IMM, LUI, AUIPC, BRANCH, JAL, JALR → ALU. LOAD, STORE → LSU. Other opcodes are popped silently (no valid).
- Issue = head valid && selected unit ready && !hazard && !i_flush; issue pops the head.
- Branch resolution on issue only: BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU by alu_op encoding; JAL target = pc+imm; JALR target = (fwd rs1 + imm) & ~1. A taken redirect discards all entries behind the head and drops any push that cycle.
- i_flush: count←0, pointers←0, push dropped, no issue; scoreboard unaffected.
- ARF write and read of the same reg in the same cycle returns the new data via the forwarding path; the ARF is not write-through.

## Timing
- Reset: count 0, pointers 0, scoreboard 0. o_dec_ready 1; all valids, o_branch_taken, o_branch_target, o_occupancy 0.
- Push-to-issue latency minimum 1 cycle: entry is visible at head the cycle after the push edge.
- Valids, payload and branch outputs are combinational from head state and ready inputs. o_branch_taken is a one-cycle pulse coincident with the issue handshake.
- Throughput: 1 issue/cycle while unit ready and no hazard.
- Simultaneous push+pop when not full: count unchanged.

## Configuration
- ISSUE_SCOREBOARD_EN defined: 32-bit pending mask.
  - Set bit rd on LOAD issue with rd!=0; clear on i_wb_en for i_wb_rd.
  - Set and clear of the same reg in one cycle: set wins.
  - hazard = head source reg pending and not supplied by any valid forward port.
- Undefined: hazard ≡ 0, no mask flops; software schedules load-use gaps.

## Structure
- riscv_uop_pkg: uop_t, OPCODE_* and ALU_* constants. New additions there: issue_entry_t {uop, pc} and the branch-condition alu_op mapping.
- One sub-module: existing ARF instance (2R1W, x0 hard-zero). FIFO storage and scoreboard stay inline.

## Test plan
- Push 4 ADDI (DEPTH=4) with i_alu_ready=0 → o_dec_ready=0 after 4th, o_occupancy=4; release ready → 4 issues on consecutive cycles.
- BEQ x1,x2 (both 5), imm=16, pc=0x100, 3 younger queued → o_branch_taken=1, target=0x110, occupancy 0 next cycle.
- Forward port0 and port1 both carry rd=3 (0xAA, 0xBB), head ADD x4,x3,x3 → o_op1=o_op2=0xAA; rs=0 with port rd=0 → operand 0.
- ISSUE_SCOREBOARD_EN: LW x5 issued, then ADD x6,x5,x0 → held until i_wb_en rd=5 or port carries rd=5, then issues with that value.
- i_flush asserted with occupancy 3 and i_dec_valid=1 → occupancy 0, no valids that cycle; async rst_n low mid-stream → all outputs 0 immediately.
